// File: rtl/flappy_pkg.sv
`default_nettype none
// ==== flappy_pkg : shared state encoding, timing defaults and speed helper (rev 1.0) ====
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DYING     = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  localparam int CD_TICKS_DEF   = 10;
  localparam int OVER_HOLD_DEF  = 20;
  localparam int SPEED_STEP_DEF = 10;

  // Threshold compares instead of a divide: level = min(score / step, 3).
  function automatic logic [1:0] speed_level(input logic [15:0] score, input int step);
    int s;
    s = int'(score);
    if (s >= 3 * step)      return 2'd3;
    else if (s >= 2 * step) return 2'd2;
    else if (s >= step)     return 2'd1;
    else                    return 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ==== btn_edge : rising-edge detector for a debounced button level (rev 1.0) ====
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low until the button is seen released, so a press held
  // through reset release is not mistaken for a new press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= btn;
      armed <= armed | ~btn;
    end
  end

  assign rise = btn & ~prev & armed;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ==== game_sequencer : game-flow FSM (countdown, play, pause, dying, over) (rev 1.0) ====
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int CD_TICKS   = CD_TICKS_DEF,
  parameter int OVER_HOLD  = OVER_HOLD_DEF,
  parameter int SPEED_STEP = SPEED_STEP_DEF
) (
  input  logic        clk_100ms,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        mode,
  input  logic        fail,
  input  logic [15:0] score,
  output logic [2:0]  state,
  output logic        core_rst_n,
  output logic        step_en,
  output logic [1:0]  countdown,
  output logic        two_player,
  output logic [1:0]  speed,
  output logic [15:0] high_score,
  output logic        new_record
);

  localparam logic [7:0] CD_LAST   = 8'(CD_TICKS - 1);
  localparam logic [7:0] HOLD_LAST = 8'(OVER_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [1:0]  cd_d;
  logic [1:0]  speed_d;
  logic        record_d;
  logic        start_rise, pause_rise;

  btn_edge u_start_edge (.clk(clk_100ms), .rst(rst), .btn(start_btn), .rise(start_rise));
  btn_edge u_pause_edge (.clk(clk_100ms), .rst(rst), .btn(pause_btn), .rise(pause_rise));

  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Tick counter falls back to 0 unless the current state keeps counting.
  always_comb begin
    state_d  = state_q;
    tick_d   = 8'd0;
    cd_d     = 2'd0;
    record_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_COUNTDOWN;
          cd_d    = 2'd3;
        end
      end
      ST_COUNTDOWN: begin
        if (tick_q == CD_LAST) begin
          if (countdown == 2'd1) state_d = ST_PLAY;
          else                   cd_d    = countdown - 2'd1;
        end else begin
          tick_d = tick_q + 8'd1;
          cd_d   = countdown;
        end
      end
      ST_PLAY: begin
        if (fail) begin
          state_d  = ST_DYING;
          record_d = (score > high_score);
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      ST_DYING: begin
        if (tick_q == HOLD_LAST) state_d = ST_OVER;
        else                     tick_d  = tick_q + 8'd1;
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_PLAY:            speed_d = speed_level(score, SPEED_STEP);
      ST_PAUSE, ST_DYING: speed_d = speed;
      default:            speed_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      tick_q     <= 8'd0;
      countdown  <= 2'd0;
      speed      <= 2'd0;
      step_en    <= 1'b0;
      core_rst_n <= 1'b0;
      two_player <= 1'b0;
      high_score <= 16'd0;
      new_record <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      countdown  <= cd_d;
      speed      <= speed_d;
      step_en    <= (state_d == ST_PLAY) || (state_d == ST_DYING);
      core_rst_n <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && start_rise) begin
        two_player <= mode;
        new_record <= 1'b0;
      end
      if (record_d) begin
        high_score <= score;
        new_record <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ==== tb_game_sequencer : scoreboard bench with directed and random game play (rev 1.0) ====
module tb_game_sequencer;

  localparam int CD   = 10;
  localparam int HOLD = 20;
  localparam int STEP = 10;

  localparam int IDLE = 0, CDOWN = 1, PLAY = 2, PAUSE = 3, DYING = 4, OVER = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0, pause_btn = 1'b0, mode = 1'b0, fail = 1'b0;
  logic [15:0] score = 16'd0;
  logic [2:0]  state;
  logic        core_rst_n, step_en, two_player, new_record;
  logic [1:0]  countdown, speed;
  logic [15:0] high_score;

  int n_cmp = 0;
  int n_err = 0;

  logic [26:0] exp_q[$];

  // Reference model: phase plus ticks spent in it, button history as last sampled level.
  int m_st, m_t, m_last_s, m_last_p, m_hs, m_nr, m_tp, m_spd;

  game_sequencer #(.CD_TICKS(CD), .OVER_HOLD(HOLD), .SPEED_STEP(STEP)) dut (
    .clk_100ms(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .mode(mode), .fail(fail), .score(score), .state(state), .core_rst_n(core_rst_n),
    .step_en(step_en), .countdown(countdown), .two_player(two_player), .speed(speed),
    .high_score(high_score), .new_record(new_record)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end within time limit");
    $fatal(1);
  end

  task automatic model_reset();
    m_st = IDLE; m_t = 0; m_hs = 0; m_nr = 0; m_tp = 0; m_spd = 0;
    m_last_s = 1; m_last_p = 1;
  endtask

  task automatic model_step();
    int  nst, sc, lvl;
    bit  sr, pr;
    if (!rst) begin
      model_reset();
      return;
    end
    sr = start_btn && (m_last_s == 0);
    pr = pause_btn && (m_last_p == 0);
    m_last_s = start_btn;
    m_last_p = pause_btn;
    sc  = int'(score);
    nst = m_st;
    case (m_st)
      IDLE:  if (sr) begin nst = CDOWN; m_t = 0; m_tp = mode; m_nr = 0; end
      CDOWN: begin
        m_t++;
        if (m_t == 3 * CD) begin nst = PLAY; m_t = 0; end
      end
      PLAY: begin
        if (fail) begin
          nst = DYING; m_t = 0;
          if (sc > m_hs) begin m_hs = sc; m_nr = 1; end
        end else if (pr) nst = PAUSE;
      end
      PAUSE: if (pr) nst = PLAY;
      DYING: begin
        m_t++;
        if (m_t == HOLD) begin nst = OVER; m_t = 0; end
      end
      default: if (sr) nst = IDLE;
    endcase
    m_st = nst;
    lvl = sc / STEP;
    if (m_st == PLAY) m_spd = (lvl > 3) ? 3 : lvl;
    else if (m_st != PAUSE && m_st != DYING) m_spd = 0;
  endtask

  function automatic logic [26:0] exp_vec();
    logic [2:0] st;
    logic [1:0] cd, sp;
    logic [15:0] hs;
    st = 3'(m_st);
    cd = (m_st == CDOWN) ? 2'(3 - m_t / CD) : 2'd0;
    sp = 2'(m_spd);
    hs = 16'(m_hs);
    return {st, (m_st != IDLE), (m_st == PLAY || m_st == DYING), cd,
            (m_tp != 0), sp, hs, (m_nr != 0)};
  endfunction

  initial begin : monitor
    logic [26:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, core_rst_n, step_en, countdown, two_player, speed, high_score, new_record};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t actual=%h required=%h (state %0d/%0d)",
                   $time, a, e, a[26:24], e[26:24]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    model_step();
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_state", int'(state), IDLE);
    check("rst_core_rst_n", int'(core_rst_n), 0);
    check("rst_step_en", int'(step_en), 0);
    check("rst_high_score", int'(high_score), 0);
    check("rst_countdown", int'(countdown), 0);
    check("rst_speed", int'(speed), 0);
    model_reset();
  endtask

  // From OVER (or IDLE with start low): reach PLAY through a full countdown.
  task automatic to_play();
    start_btn = 1'b1; tick();
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    check("game_start_new_record", int'(new_record), 0);
    start_btn = 1'b0;
    repeat (3 * CD) tick();
    check("reach_play", int'(state), PLAY);
  endtask

  initial begin : stimulus
    int sweep_in[5]  = '{9, 10, 29, 30, 200};
    int sweep_out[5] = '{0, 1, 2, 3, 3};

    model_reset();
    repeat (2) tick();
    check("init_state", int'(state), IDLE);
    check("init_core_rst_n", int'(core_rst_n), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Countdown timing and entry into PLAY.
    mode = 1'b1; start_btn = 1'b1; tick();
    check("cd_enter", int'(state), CDOWN);
    check("cd_digit3", int'(countdown), 3);
    repeat (CD - 1) tick();
    check("cd_digit3_last", int'(countdown), 3);
    tick();
    check("cd_digit2", int'(countdown), 2);
    repeat (CD) tick();
    check("cd_digit1", int'(countdown), 1);
    start_btn = 1'b0;
    repeat (CD - 1) tick();
    check("cd_still_at_29", int'(state), CDOWN);
    tick();
    check("play_at_30", int'(state), PLAY);
    check("play_step_en", int'(step_en), 1);
    check("two_player_latched", int'(two_player), 1);

    // Pause ignores fail; second pause press resumes.
    pause_btn = 1'b1; tick();
    check("pause_enter", int'(state), PAUSE);
    check("pause_step_en", int'(step_en), 0);
    pause_btn = 1'b0; fail = 1'b1;
    repeat (5) tick();
    check("pause_ignores_fail", int'(state), PAUSE);
    fail = 1'b0; tick();
    pause_btn = 1'b1; tick();
    check("pause_resume", int'(state), PLAY);
    pause_btn = 1'b0; tick();

    // Speed thresholds.
    for (int i = 0; i < 5; i++) begin
      score = 16'(sweep_in[i]);
      tick();
      check($sformatf("speed_at_%0d", sweep_in[i]), int'(speed), sweep_out[i]);
    end

    // Game 1: fail beats pause on the same tick, new record 17.
    score = 16'd17; pause_btn = 1'b1; fail = 1'b1; tick();
    check("fail_wins", int'(state), DYING);
    check("g1_high_score", int'(high_score), 17);
    check("g1_new_record", int'(new_record), 1);
    pause_btn = 1'b0; fail = 1'b0;
    repeat (HOLD - 1) tick();
    check("dying_hold", int'(state), DYING);
    tick();
    check("over_enter", int'(state), OVER);
    check("over_step_en", int'(step_en), 0);

    // Game 2: tie does not update.
    to_play();
    score = 16'd17; fail = 1'b1; tick();
    check("g2_high_score", int'(high_score), 17);
    check("g2_new_record", int'(new_record), 0);
    fail = 1'b0;
    repeat (HOLD) tick();

    // Game 3: higher score updates.
    to_play();
    score = 16'd25; fail = 1'b1; tick();
    check("g3_high_score", int'(high_score), 25);
    check("g3_new_record", int'(new_record), 1);
    fail = 1'b0;
    repeat (HOLD) tick();

    // Reset mid-countdown with start held.
    start_btn = 1'b1; tick();
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    repeat (5) tick();
    do_reset();
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("held_start_no_restart", int'(state), IDLE);
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    check("restart_after_release", int'(state), CDOWN);
    start_btn = 1'b0;

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)  start_btn = ~start_btn;
      if ($urandom_range(0, 9) == 0)  pause_btn = ~pause_btn;
      fail = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0)  score = 16'($urandom_range(0, 45));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      tick();
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        repeat (2) tick();
        rst = 1'b1;
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter CD_TICKS, default 10: clk_100ms ticks per countdown digit.
REQ-002 Parameter OVER_HOLD, default 20: ticks spent in DYING before OVER.
REQ-003 Parameter SPEED_STEP, default 10: score points per speed level.
REQ-004 clk_100ms  in  1  game tick clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start_btn  in  1  debounced start level; the block acts only on its rising edge.
REQ-007 pause_btn  in  1  debounced pause level; the block acts only on its rising edge.
REQ-008 mode  in  1  1 = two-player, 0 = single-player; sampled at game start.
REQ-009 fail  in  1  collision flag from the physics core, level.
REQ-010 score  in  16  current score from the physics core, unsigned.
REQ-011 state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, DYING=4, OVER=5.
REQ-012 core_rst_n  out  1  active-low reset to the physics core.
REQ-013 step_en  out  1  physics advance enable.
REQ-014 countdown  out  2  digit shown during COUNTDOWN (3..1); 0 in all other states.
REQ-015 two_player  out  1  mode latched at game start.
REQ-016 speed  out  2  scroll speed level, 0..3.
REQ-017 high_score  out  16  best score since reset.
REQ-018 new_record  out  1  last finished game set a new high score.

Function
REQ-019 The block SHALL register start_btn and pause_btn once, and define start_rise and pause_rise as current=1 and previous=0.
REQ-020 IDLE SHALL drive core_rst_n=0 and step_en=0; on start_rise it SHALL go to COUNTDOWN, load countdown=3, clear the tick counter, latch two_player<=mode, and clear new_record.
REQ-021 COUNTDOWN SHALL drive core_rst_n=1 and step_en=0.
REQ-022 In COUNTDOWN the tick counter SHALL increment each tick; at CD_TICKS-1 it SHALL wrap to 0 and decrement countdown.
REQ-023 A wrap with countdown=1 SHALL enter PLAY, so COUNTDOWN lasts exactly 3*CD_TICKS ticks.
REQ-024 PLAY SHALL drive step_en=1.
REQ-025 In PLAY, fail=1 SHALL enter DYING; otherwise pause_rise SHALL enter PAUSE. When both occur on the same tick, fail wins.
REQ-026 PAUSE SHALL drive step_en=0 and ignore fail and start_rise; pause_rise SHALL return to PLAY.
REQ-027 On the PLAY->DYING transition, if score > high_score, then high_score<=score and new_record<=1; a tie SHALL NOT update either.
REQ-028 DYING SHALL drive step_en=1 so the bird falls, and after OVER_HOLD ticks it SHALL enter OVER; start_rise SHALL be ignored during DYING.
REQ-029 OVER SHALL drive step_en=0 with core_rst_n=1 (frozen scene); start_rise SHALL go to IDLE.
REQ-030 In PLAY, speed SHALL be registered as min(floor(score/SPEED_STEP),3) using comparisons against SPEED_STEP, 2*SPEED_STEP and 3*SPEED_STEP, with no divider.
REQ-031 speed SHALL hold its value through PAUSE and DYING, and be 0 in IDLE, COUNTDOWN and OVER.
REQ-032 step_en, core_rst_n and countdown SHALL be registered outputs decoded from the next state, so they change on the same edge as state.
REQ-033 Undefined state codes 6 and 7 SHALL return to IDLE on the next tick.

Reset
REQ-034 rst=0 SHALL force, immediately and asynchronously:
- state=IDLE, core_rst_n=0, step_en=0
- countdown=0, speed=0, two_player=0
- high_score=0, new_record=0
- tick counter=0, both button history registers=0
REQ-035 A button held high while rst is released SHALL NOT produce a rise event.
REQ-036 high_score SHALL be cleared only by rst, never by a game restart.

Structure
REQ-037 The state encodings and the default values of CD_TICKS, OVER_HOLD and SPEED_STEP SHALL live in the shared package flappy_pkg.
REQ-038 Rising-edge detection SHALL be one sub-module, btn_edge, instantiated twice (start, pause).
REQ-039 The tick counter SHALL be 8 bits wide and shared by COUNTDOWN and DYING, cleared on every state change.

Verification
REQ-040 Reset, then start_btn 0->1 -> COUNTDOWN with countdown=3, then 2 after 10 ticks and 1 after 20; PLAY with step_en=1 exactly 30 ticks after the start edge.
REQ-041 In PLAY, raise pause_btn and fail on the same tick -> DYING (not PAUSE); after 20 ticks -> OVER with step_en=0.
REQ-042 In PLAY, pause_rise -> PAUSE with step_en=0; fail=1 during PAUSE -> no change; second pause_rise -> PLAY.
REQ-043 Game 1 ends with score=17 -> high_score=17, new_record=1; game 2 ends with score=17 -> high_score stays 17, new_record=0; game 3 ends with score=25 -> high_score=25.
REQ-044 In PLAY, sweep score through 9, 10, 29, 30, 200 -> speed 0, 1, 2, 3, 3.
REQ-045 Assert rst mid-COUNTDOWN with start_btn held high -> IDLE at once, core_rst_n=0, high_score=0, and no restart until start_btn falls and rises again.
